// File: rtl/ioctl_upload_server.sv
// Core-side responder for HPS file uploads over ioctl. It raises the upload request,
// then answers each byte-read strobe from a synchronous RAM and stalls the HPS with ioctl_wait.
module ioctl_upload_server #(
  parameter int          ADDR_W       = 17,
  parameter int unsigned SIZE         = 32'h10000,
  parameter int          RAM_LATENCY  = 2,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd5
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              save_req,
  output logic              ioctl_upload_req,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACTIVE,
    FETCH,
    HOLD
  } state_t;

  localparam logic [2:0]      LAT_LAST  = 3'(RAM_LATENCY - 1);
  localparam logic [24:0]     SIZE_ADDR = 25'(SIZE);
  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W + 1)'(1);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       active;
  logic       in_range;
  logic       transfer_state;

  assign active         = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign in_range       = ioctl_addr < SIZE_ADDR;
  assign transfer_state = (state == ACTIVE) || (state == FETCH) || (state == HOLD);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      lat_cnt          <= '0;
      ioctl_upload_req <= 1'b0;
      ioctl_din        <= 8'h00;
      ioctl_wait       <= 1'b0;
      ram_addr         <= '0;
      ram_rd           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      byte_count       <= '0;
      overrun          <= 1'b0;
    end else begin
      ram_rd <= 1'b0;
      done   <= 1'b0;
      // Losing the HPS session abandons any pending fetch; ioctl_din keeps its last byte.
      if (transfer_state && !active) begin
        state      <= IDLE;
        ioctl_wait <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (save_req) begin
              state            <= REQ;
              ioctl_upload_req <= 1'b1;
              busy             <= 1'b1;
              byte_count       <= '0;
              overrun          <= 1'b0;
            end
          end
          REQ: begin
            if (active) begin
              ioctl_upload_req <= 1'b0;
              state            <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (ioctl_rd) begin
              if (byte_count != '1) byte_count <= byte_count + COUNT_ONE;
              ioctl_wait <= 1'b1;
              if (in_range) begin
                ram_addr <= ioctl_addr[ADDR_W-1:0];
                ram_rd   <= 1'b1;
                lat_cnt  <= '0;
                state    <= FETCH;
              end else begin
                ioctl_din <= 8'hFF;
                state     <= HOLD;
              end
            end
          end
          FETCH: begin
            if (ioctl_rd) overrun <= 1'b1;
            if (lat_cnt == LAT_LAST) begin
              ioctl_din <= ram_dout;
              state     <= HOLD;
            end else begin
              lat_cnt <= lat_cnt + 3'd1;
            end
          end
          HOLD: begin
            if (ioctl_rd) overrun <= 1'b1;
            ioctl_wait <= 1'b0;
            state      <= ACTIVE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Self-checking bench for ioctl_upload_server: scoreboarded byte reads against a
// registered-read RAM model, plus request, range, overrun, abort and reset scenarios.
module tb_ioctl_upload_server;

  logic        clk_sys;
  logic        reset_n;
  logic        save_req;
  logic        ioctl_upload_req;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [16:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_dout;
  logic        busy;
  logic        done;
  logic [17:0] byte_count;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem[0:131071];

  ioctl_upload_server dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .save_req         (save_req),
    .ioctl_upload_req (ioctl_upload_req),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_din        (ioctl_din),
    .ioctl_wait       (ioctl_wait),
    .ram_addr         (ram_addr),
    .ram_rd           (ram_rd),
    .ram_dout         (ram_dout),
    .busy             (busy),
    .done             (done),
    .byte_count       (byte_count),
    .overrun          (overrun)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // RAM with one registered read stage: together with the strobe cycle this is a latency of 2.
  initial begin
    ram_dout = 8'h00;
    for (int i = 0; i < 131072; i++) mem[i] = 8'((i * 13) ^ (i >> 5) ^ 8'h3C);
    mem[17'h0123] = 8'hA5;
  end

  always @(posedge clk_sys) if (ram_rd) ram_dout <= mem[ram_addr];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic start_upload(input bit chk_idx);
    save_req = 1'b1;
    @(negedge clk_sys);
    save_req = 1'b0;
    n_cmp++;
    if ({ioctl_upload_req, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL start_req_busy: got req/busy=%b want 11", {ioctl_upload_req, busy});
    end
    n_cmp++;
    if (overrun !== 1'b0 || byte_count !== 18'd0) begin
      n_bad++;
      $display("FAIL start_clear: got overrun=%b count=%0d want 0/0", overrun, byte_count);
    end
    if (chk_idx) begin
      ioctl_index  = 8'd3;
      ioctl_upload = 1'b1;
      @(negedge clk_sys);
      n_cmp++;
      if (ioctl_upload_req !== 1'b1) begin
        n_bad++;
        $display("FAIL req_wrong_index: got req=%b want 1", ioctl_upload_req);
      end
    end
    ioctl_index  = 8'd5;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    n_cmp++;
    if ({ioctl_upload_req, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL req_drop: got req/busy=%b want 01", {ioctl_upload_req, busy});
    end
    $display("upload started busy=%b req=%b", busy, ioctl_upload_req);
  endtask

  // One read: push the expected byte, strobe, follow ioctl_wait down (bounded), pop and compare.
  task automatic do_read(input logic [24:0] a, input logic [7:0] exp);
    int waits;
    int pulses;
    int want_waits;
    logic [7:0] want;
    want_waits = (a < 25'h10000) ? 3 : 1;
    exp_q.push_back(exp);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    waits  = 0;
    pulses = 0;
    while (ioctl_wait === 1'b1 && waits < 12) begin
      if (ram_rd === 1'b1) begin
        pulses++;
        n_cmp++;
        if (ram_addr !== a[16:0]) begin
          n_bad++;
          $display("FAIL ram_addr: got %h want %h", ram_addr, a[16:0]);
        end
      end
      waits++;
      @(negedge clk_sys);
    end
    if (ram_rd === 1'b1) pulses++;
    n_cmp++;
    if (waits !== want_waits) begin
      n_bad++;
      $display("FAIL wait_cycles addr=%h: got %0d want %0d", a, waits, want_waits);
    end
    n_cmp++;
    if (pulses !== ((a < 25'h10000) ? 1 : 0)) begin
      n_bad++;
      $display("FAIL ram_rd_pulses addr=%h: got %0d want %0d", a, pulses, (a < 25'h10000) ? 1 : 0);
    end
    want = exp_q.pop_front();
    n_cmp++;
    if (ioctl_din !== want) begin
      n_bad++;
      $display("FAIL read_data addr=%h: got %h want %h", a, ioctl_din, want);
    end
    $display("rd addr=%h din=%h waits=%0d count=%0d", a, ioctl_din, waits, byte_count);
  endtask

  task automatic test_reset;
    reset_n      = 1'b0;
    save_req     = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if ({ioctl_upload_req, ioctl_wait, ram_rd, busy, done, overrun} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {ioctl_upload_req, ioctl_wait, ram_rd, busy, done, overrun});
    end
    n_cmp++;
    if (ioctl_din !== 8'h00 || ram_addr !== 17'd0 || byte_count !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_values: got din=%h addr=%h count=%0d want 00/0/0", ioctl_din, ram_addr, byte_count);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    $display("reset released");
  endtask

  task automatic test_request;
    start_upload(1'b1);
  endtask

  task automatic test_in_range;
    logic       want_w[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       want_r[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] want;
    exp_q.push_back(mem[17'h0123]);
    ioctl_addr = 25'h0123;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (ioctl_wait !== want_w[k-1] || ram_rd !== want_r[k-1]) begin
        n_bad++;
        $display("FAIL inrange_T+%0d: got wait/ram_rd=%b%b want %b%b", k, ioctl_wait, ram_rd, want_w[k-1], want_r[k-1]);
      end
      if (k == 1) begin
        n_cmp++;
        if (ram_addr !== 17'h0123) begin
          n_bad++;
          $display("FAIL inrange_addr: got %h want 0123", ram_addr);
        end
      end
      if (k == 3) begin
        want = exp_q.pop_front();
        n_cmp++;
        if (ioctl_din !== want) begin
          n_bad++;
          $display("FAIL inrange_din_T+3: got %h want %h", ioctl_din, want);
        end
      end
      if (k < 4) @(negedge clk_sys);
    end
    n_cmp++;
    if (byte_count !== 18'd1) begin
      n_bad++;
      $display("FAIL inrange_count: got %0d want 1", byte_count);
    end
    $display("rd addr=000123 din=%h count=%0d", ioctl_din, byte_count);
  endtask

  task automatic test_out_of_range;
    do_read(25'h10000, 8'hFF);
    do_read(25'h1_0123, 8'hFF);
    n_cmp++;
    if (byte_count !== 18'd3) begin
      n_bad++;
      $display("FAIL oor_count: got %0d want 3", byte_count);
    end
  endtask

  task automatic test_overrun;
    int         waits;
    logic [7:0] want;
    exp_q.push_back(mem[17'h0200]);
    ioctl_addr = 25'h0200;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_addr = 25'h10000;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    waits = 0;
    while (ioctl_wait === 1'b1 && waits < 12) begin
      waits++;
      @(negedge clk_sys);
    end
    n_cmp++;
    if (waits >= 12) begin
      n_bad++;
      $display("FAIL overrun_wait_timeout: got %0d cycles want <12", waits);
    end
    want = exp_q.pop_front();
    n_cmp++;
    if (ioctl_din !== want) begin
      n_bad++;
      $display("FAIL overrun_data: got %h want %h", ioctl_din, want);
    end
    n_cmp++;
    if (overrun !== 1'b1 || byte_count !== 18'd4) begin
      n_bad++;
      $display("FAIL overrun_flag: got overrun=%b count=%0d want 1/4", overrun, byte_count);
    end
    $display("rd addr=000200 with overrun din=%h overrun=%b", ioctl_din, overrun);
  endtask

  task automatic drop_and_check_done(input string tag);
    int pulses;
    ioctl_upload = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      if (done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL %s_done_pulses: got %0d want 1", tag, pulses);
    end
    n_cmp++;
    if ({busy, ioctl_wait, ioctl_upload_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s_idle: got busy/wait/req=%b want 000", tag, {busy, ioctl_wait, ioctl_upload_req});
    end
    $display("upload ended done_pulses=%0d busy=%b", pulses, busy);
  endtask

  task automatic test_ignored_index;
    int seen;
    ioctl_index  = 8'd3;
    ioctl_upload = 1'b1;
    ioctl_addr   = 25'h0123;
    ioctl_rd     = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (ram_rd === 1'b1 || ioctl_wait === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk_sys);
    end
    n_cmp++;
    if (seen !== 0 || byte_count !== 18'd4) begin
      n_bad++;
      $display("FAIL index3_ignored: got activity=%0d count=%0d want 0/4", seen, byte_count);
    end
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd5;
    @(negedge clk_sys);
    $display("rd index=3 ignored");
  endtask

  task automatic test_back_to_back;
    start_upload(1'b0);
    for (int i = 0; i < 256; i++) begin
      logic [24:0] a;
      a = 25'h0FF00 + 25'(i);
      do_read(a, mem[a[16:0]]);
    end
    n_cmp++;
    if (byte_count !== 18'd256) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want 256", byte_count);
    end
    drop_and_check_done("b2b");
  endtask

  task automatic test_reset_mid_fetch;
    int pulses;
    start_upload(1'b0);
    ioctl_addr = 25'h0123;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    n_cmp++;
    if (ram_rd !== 1'b1 || ioctl_wait !== 1'b1) begin
      n_bad++;
      $display("FAIL midfetch_pre: got ram_rd/wait=%b%b want 11", ram_rd, ioctl_wait);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ioctl_upload_req, ioctl_wait, ram_rd, busy, done, overrun} !== 6'b0) begin
      n_bad++;
      $display("FAIL async_reset_flags: got %b want 000000",
               {ioctl_upload_req, ioctl_wait, ram_rd, busy, done, overrun});
    end
    n_cmp++;
    if (ioctl_din !== 8'h00 || ram_addr !== 17'd0 || byte_count !== 18'd0) begin
      n_bad++;
      $display("FAIL async_reset_values: got din=%h addr=%h count=%0d want 00/0/0", ioctl_din, ram_addr, byte_count);
    end
    ioctl_upload = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      if (done === 1'b1) pulses++;
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    if (done === 1'b1) pulses++;
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: got %0d pulses want 0", pulses);
    end
    $display("reset during fetch, outputs cleared");
    start_upload(1'b0);
    do_read(25'h0123, mem[17'h0123]);
    drop_and_check_done("post_reset");
  endtask

  initial begin
    test_reset();
    test_request();
    test_in_range();
    test_out_of_range();
    test_overrun();
    drop_and_check_done("abort");
    test_ignored_index();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ioctl_upload_server.md
# ioctl_upload_server

Core-side responder for the HPS file-upload direction of the ioctl channel: the counterpart of the existing download path that writes BIOS, sprite and music images into the core. It requests an upload, answers each HPS byte-read strobe by fetching from a synchronous core RAM port, and holds the HPS off with `ioctl_wait` until the byte is valid. It sits between `hps_io` and the `system` memory map, sharing its 17-bit address space with the download path.

## Interface
Parameters:
- `ADDR_W`, 17: RAM address width; matches the `dn_addr` width.
- `SIZE`, 17'h10000: number of servable bytes; reads at or beyond `SIZE` do not touch RAM.
- `RAM_LATENCY`, 2: cycles from `ram_rd` to valid `ram_dout`; legal range 1-4.
- `UPLOAD_INDEX`, 8'd5: `ioctl_index` value this block answers.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `save_req` in 1: one-cycle request from the core to start an upload.
- `ioctl_upload_req` out 1: upload request level to `hps_io`.
- `ioctl_upload` in 1: HPS upload-active level.
- `ioctl_index` in 8: current ioctl file index.
- `ioctl_rd` in 1: one-cycle HPS byte-read strobe.
- `ioctl_addr` in 25: byte address, sampled with `ioctl_rd`.
- `ioctl_din` out 8: byte returned to the HPS.
- `ioctl_wait` out 1: stalls the HPS while a fetch is pending.
- `ram_addr` out ADDR_W: RAM read address.
- `ram_rd` out 1: one-cycle RAM read strobe.
- `ram_dout` in 8: RAM read data.
- `busy` out 1: high from the accepted `save_req` until the return to IDLE.
- `done` out 1: one-cycle pulse at the end of an upload.
- `byte_count` out ADDR_W+1: number of bytes served in the current or last upload.
- `overrun` out 1: sticky flag; set when `ioctl_rd` arrives during a fetch, cleared by the next accepted `save_req`.

## Operation
- `active` is defined as `ioctl_upload && ioctl_index == UPLOAD_INDEX`.
- State IDLE:
  - `save_req` moves the block to REQ, sets `busy`, clears `byte_count` and `overrun`.
  - `save_req` in any other state is ignored.
- State REQ:
  - `ioctl_upload_req` is held high.
  - On the first cycle with `active` high, `ioctl_upload_req` drops and the block moves to ACTIVE.
- State ACTIVE, on `ioctl_rd`:
  - Address in range (`ioctl_addr < SIZE`): drive `ram_addr` with `ioctl_addr[ADDR_W-1:0]`, pulse `ram_rd`, and move to FETCH.
  - Address out of range: load `ioctl_din` with 8'hFF and go to HOLD without touching RAM.
  - Either way, `byte_count` increments (saturating at all-ones).
- State FETCH: a latency counter runs for RAM_LATENCY cycles, then `ioctl_din` loads `ram_dout` and the block moves to HOLD.
- State HOLD: one cycle; returns to ACTIVE.
- `ioctl_wait` is high in FETCH and HOLD.
- `ioctl_rd` seen in FETCH or HOLD is dropped and sets `overrun`.
- `active` falling in ACTIVE, FETCH or HOLD aborts any pending fetch: `done` pulses, `busy` clears, and the block returns to IDLE. `ioctl_din` keeps its last value.
- `ioctl_rd` with `active` low, or in IDLE/REQ, is ignored.

## Timing
- Reset values: state IDLE, `ioctl_upload_req`=0, `ioctl_din`=8'h00, `ioctl_wait`=0, `ram_addr`=0, `ram_rd`=0, `busy`=0, `done`=0, `byte_count`=0, `overrun`=0.
- Reset asserted mid-upload forces all of the above immediately; no `done` pulse is produced.
- All outputs are registered.
- In-range read, with `ioctl_rd` sampled at edge T:
  - `ram_rd` and `ioctl_wait` are high from T+1.
  - `ram_rd` stays high for exactly one cycle.
  - `ioctl_din` is valid from T+1+RAM_LATENCY.
  - `ioctl_wait` falls at T+2+RAM_LATENCY, after one HOLD cycle.
- Out-of-range read: `ioctl_din`=FF and `ioctl_wait` high at T+1; `ioctl_wait` low at T+2.
- `ioctl_upload_req` rises one cycle after `save_req` is sampled.
- `done` pulses one cycle after `active` is seen low.
- Back-to-back reads are legal once `ioctl_wait` is low; a new `ioctl_rd` is accepted in the same cycle the block re-enters ACTIVE.

## Test plan
- Reset, then `save_req`: `ioctl_upload_req`=1 and `busy`=1 the next cycle; raise `ioctl_upload` with index 5 -> `ioctl_upload_req` drops one cycle later.
- Preload RAM[0x0123]=8'hA5 with RAM_LATENCY=2; `ioctl_rd` at address 0x0123 -> `ram_rd` pulses with `ram_addr`=0x0123, `ioctl_din`=A5 at T+3, `ioctl_wait` high T+1..T+3, `byte_count`=1.
- `ioctl_rd` at address 0x10000 with SIZE=0x10000 -> `ram_rd` never asserts, `ioctl_din`=FF, `ioctl_wait` high exactly one cycle.
- 256 back-to-back reads, each issued as soon as `ioctl_wait` falls -> every byte matches RAM, `byte_count`=256, then drop `ioctl_upload` -> one `done` pulse and `busy`=0.
- `ioctl_rd` during FETCH -> `overrun`=1 and the fetch completes unaffected; `ioctl_rd` with index 3 -> no response.
- `reset_n` low during FETCH -> all outputs return to reset values asynchronously with no `done` pulse; a subsequent `save_req` works normally.
